// File: rtl/arbitro_memoria_tabuleiro_pkg.sv
// Shared types for the board-memory arbiter: FSM states, read-return owner codes and board geometry.
package arbitro_memoria_tabuleiro_pkg;

    localparam int unsigned WordW = 64;
    localparam int unsigned AddrW = 5;

    typedef enum logic [1:0] {
        StIdleVga   = 2'd0,
        StGrantVal  = 2'd1,
        StGrantCol  = 2'd2,
        StGrantPont = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OwnVal  = 2'd0,
        OwnCol  = 2'd1,
        OwnPont = 2'd2,
        OwnVga  = 2'd3
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   jogador;
    } rd_tag_t;

    localparam int unsigned TagW = $bits(rd_tag_t);

    // Fixed priority: validator, then collider, then score.
    function automatic arb_state_e pick_grant(logic val_req, logic col_req, logic pont_req);
        if (val_req) begin
            return StGrantVal;
        end else if (col_req) begin
            return StGrantCol;
        end else if (pont_req) begin
            return StGrantPont;
        end
        return StIdleVga;
    endfunction

endpackage

// File: rtl/arbitro_memoria_tabuleiro_read_tag_pipe.sv
// Read tag pipeline: Depth-stage shift register of {valid, owner, jogador} matching RAM read latency.
module arbitro_memoria_tabuleiro_read_tag_pipe
    import arbitro_memoria_tabuleiro_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [TagW-1:0] tag_i,
    output logic [TagW-1:0] tag_o
);

    logic [Depth-1:0][TagW-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/arbitro_memoria_tabuleiro.sv
// Arbiter for the shared P1/P2 board RAM port: validator > collider > score, VGA fills idle cycles.
// Define ARB_BURST_LIMIT_EN to force a one-cycle release after MAX_BURST accesses per grant.
module arbitro_memoria_tabuleiro
    import arbitro_memoria_tabuleiro_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 32
) (
    input  logic             clk,
    input  logic             resetGeral,
    input  logic             val_req,
    input  logic             col_req,
    input  logic             pont_req,
    input  logic             val_we,
    input  logic             col_we,
    input  logic             val_jogador,
    input  logic             col_jogador,
    input  logic             pont_jogador,
    input  logic [AddrW-1:0] val_addr,
    input  logic [AddrW-1:0] col_addr,
    input  logic [AddrW-1:0] pont_addr,
    input  logic [WordW-1:0] val_wdata,
    input  logic [WordW-1:0] col_wdata,
    output logic             val_gnt,
    output logic             col_gnt,
    output logic             pont_gnt,
    output logic             val_rvalid,
    output logic             col_rvalid,
    output logic             pont_rvalid,
    output logic             vga_rvalid,
    output logic [WordW-1:0] rdata,
    input  logic [AddrW-1:0] vga_addr,
    input  logic             vga_jogador,
    output logic [AddrW-1:0] mem_addr,
    output logic [WordW-1:0] mem_data,
    output logic             mem_wrenP1,
    output logic             mem_wrenP2,
    input  logic [WordW-1:0] mem_q_p1,
    input  logic [WordW-1:0] mem_q_p2
);

    if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
        $error("RD_LAT must be 1 or 2");
    end
    if (MAX_BURST < 1 || MAX_BURST > 63) begin : g_bad_max_burst
        $error("MAX_BURST must fit the 6-bit burst counter");
    end

    arb_state_e       state_q, state_d;
    logic             held;
    logic             limit_hit;

    logic             acc_valid, acc_we, acc_jog;
    owner_e           acc_owner;
    logic [AddrW-1:0] acc_addr;
    logic [WordW-1:0] acc_wdata;

    rd_tag_t          tag_in, tag_out;

    logic [AddrW-1:0] mem_addr_q, mem_addr_d;
    logic [WordW-1:0] mem_data_q, mem_data_d;
    logic             wren_p1_q, wren_p1_d, wren_p2_q, wren_p2_d;
    logic [WordW-1:0] rdata_q, rdata_d;
    logic [3:0]       rvalid_q, rvalid_d;

    // Owner of the current grant still requesting; zero outside GRANT states.
    always_comb begin
        held = 1'b0;
        unique case (state_q)
            StGrantVal:  held = val_req;
            StGrantCol:  held = col_req;
            StGrantPont: held = pont_req;
            default:     held = 1'b0;
        endcase
    end

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [5:0] BurstLast = 6'(MAX_BURST - 1);

    logic [5:0] burst_q, burst_d;

    assign limit_hit = held && (burst_q == BurstLast);
    assign burst_d   = (held && (state_d == state_q)) ? burst_q + 6'd1 : 6'd0;

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            burst_q <= 6'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            state_q <= StIdleVga;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are locked while held; a release re-arbitrates on the same edge.
    always_comb begin
        state_d = state_q;
        if (limit_hit) begin
            state_d = StIdleVga;
        end else if (!held) begin
            state_d = pick_grant(val_req, col_req, pont_req);
        end
    end

    assign val_gnt  = (state_q == StGrantVal);
    assign col_gnt  = (state_q == StGrantCol);
    assign pont_gnt = (state_q == StGrantPont);

    always_comb begin
        acc_valid = 1'b1;
        acc_owner = OwnVga;
        acc_we    = 1'b0;
        acc_jog   = vga_jogador;
        acc_addr  = vga_addr;
        acc_wdata = '0;
        unique case (state_q)
            StGrantVal: begin
                acc_valid = val_req;
                acc_owner = OwnVal;
                acc_we    = val_we;
                acc_jog   = val_jogador;
                acc_addr  = val_addr;
                acc_wdata = val_wdata;
            end
            StGrantCol: begin
                acc_valid = col_req;
                acc_owner = OwnCol;
                acc_we    = col_we;
                acc_jog   = col_jogador;
                acc_addr  = col_addr;
                acc_wdata = col_wdata;
            end
            StGrantPont: begin
                acc_valid = pont_req;
                acc_owner = OwnPont;
                acc_jog   = pont_jogador;
                acc_addr  = pont_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr_d     = acc_valid ? acc_addr : mem_addr_q;
        mem_data_d     = (acc_valid && acc_we) ? acc_wdata : mem_data_q;
        wren_p1_d      = acc_valid & acc_we & ~acc_jog;
        wren_p2_d      = acc_valid & acc_we & acc_jog;
        tag_in.valid   = acc_valid & ~acc_we;
        tag_in.owner   = acc_owner;
        tag_in.jogador = acc_jog;
    end

    arbitro_memoria_tabuleiro_read_tag_pipe #(
        .Depth(RD_LAT)
    ) u_read_tag_pipe (
        .clk_i (clk),
        .rst_ni(resetGeral),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (tag_out.valid) begin
            rvalid_d[tag_out.owner] = 1'b1;
            rdata_d = tag_out.jogador ? mem_q_p2 : mem_q_p1;
        end
    end

    always_ff @(posedge clk or negedge resetGeral) begin
        if (!resetGeral) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wren_p1_q  <= 1'b0;
            wren_p2_q  <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            wren_p1_q  <= wren_p1_d;
            wren_p2_q  <= wren_p2_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data    = mem_data_q;
    assign mem_wrenP1  = wren_p1_q;
    assign mem_wrenP2  = wren_p2_q;
    assign rdata       = rdata_q;
    assign val_rvalid  = rvalid_q[OwnVal];
    assign col_rvalid  = rvalid_q[OwnCol];
    assign pont_rvalid = rvalid_q[OwnPont];
    assign vga_rvalid  = rvalid_q[OwnVga];

endmodule

// File: tb/tb_arbitro_memoria_tabuleiro.sv
// Bench for arbitro_memoria_tabuleiro: random stimulus against a transaction-level arbiter model.
module tb_arbitro_memoria_tabuleiro;

    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned MAX_BURST = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetGeral = 1'b0;
    logic        val_req = 1'b0, col_req = 1'b0, pont_req = 1'b0;
    logic        val_we = 1'b0, col_we = 1'b0;
    logic        val_jogador = 1'b0, col_jogador = 1'b0, pont_jogador = 1'b0;
    logic [4:0]  val_addr = '0, col_addr = '0, pont_addr = '0;
    logic [63:0] val_wdata = '0, col_wdata = '0;
    logic        val_gnt, col_gnt, pont_gnt;
    logic        val_rvalid, col_rvalid, pont_rvalid, vga_rvalid;
    logic [63:0] rdata;
    logic [4:0]  vga_addr = '0;
    logic        vga_jogador = 1'b0;
    logic [4:0]  mem_addr;
    logic [63:0] mem_data;
    logic        mem_wrenP1, mem_wrenP2;
    logic [63:0] mem_q_p1 = '0, mem_q_p2 = '0;

    always #5 clk = ~clk;

    arbitro_memoria_tabuleiro #(
        .RD_LAT   (RD_LAT),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk         (clk),
        .resetGeral  (resetGeral),
        .val_req     (val_req),
        .col_req     (col_req),
        .pont_req    (pont_req),
        .val_we      (val_we),
        .col_we      (col_we),
        .val_jogador (val_jogador),
        .col_jogador (col_jogador),
        .pont_jogador(pont_jogador),
        .val_addr    (val_addr),
        .col_addr    (col_addr),
        .pont_addr   (pont_addr),
        .val_wdata   (val_wdata),
        .col_wdata   (col_wdata),
        .val_gnt     (val_gnt),
        .col_gnt     (col_gnt),
        .pont_gnt    (pont_gnt),
        .val_rvalid  (val_rvalid),
        .col_rvalid  (col_rvalid),
        .pont_rvalid (pont_rvalid),
        .vga_rvalid  (vga_rvalid),
        .rdata       (rdata),
        .vga_addr    (vga_addr),
        .vga_jogador (vga_jogador),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wrenP1  (mem_wrenP1),
        .mem_wrenP2  (mem_wrenP2),
        .mem_q_p1    (mem_q_p1),
        .mem_q_p2    (mem_q_p2)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner -1 = idle (VGA), 0 val, 1 col, 2 pont; expectations hold for the current cycle.
    typedef struct {
        int cyc;
        int owner;
        bit jog;
    } rd_t;

    rd_t         rdq[$];
    int          m_owner = -1;
    int          m_burst = 0;
    int          cyc = 0;
    logic [2:0]  e_gnt = '0;
    logic [3:0]  e_rvalid = '0;
    logic [63:0] e_rdata = '0;
    bit          e_acc = 1'b1, e_dchk = 1'b1, e_wr1 = 1'b0, e_wr2 = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [63:0] e_data = '0;

    // Board RAM read data: a fresh random word every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_q_p1 = {$urandom, $urandom};
            mem_q_p2 = {$urandom, $urandom};
        end
    end

    initial begin : model
        int          acc_owner;
        bit          acc_we, acc_jog, hit;
        logic [4:0]  acc_addr;
        logic [63:0] acc_wd;
        logic [2:0]  req;
        int          prev;
        rd_t         r;
        forever begin
            @(posedge clk or negedge resetGeral);
            if (!resetGeral) begin
                m_owner = -1; m_burst = 0; rdq.delete();
                e_gnt = '0; e_rvalid = '0; e_rdata = '0;
                e_acc = 1'b1; e_dchk = 1'b1; e_addr = '0; e_data = '0; e_wr1 = 1'b0; e_wr2 = 1'b0;
            end else begin
                req = {pont_req, col_req, val_req};
                acc_owner = -1; acc_we = 1'b0; acc_jog = 1'b0; acc_addr = '0; acc_wd = '0;
                if (m_owner < 0) begin
                    acc_owner = 3; acc_jog = vga_jogador; acc_addr = vga_addr;
                end else if (req[m_owner]) begin
                    acc_owner = m_owner;
                    case (m_owner)
                        0: begin
                            acc_we = val_we; acc_jog = val_jogador;
                            acc_addr = val_addr; acc_wd = val_wdata;
                        end
                        1: begin
                            acc_we = col_we; acc_jog = col_jogador;
                            acc_addr = col_addr; acc_wd = col_wdata;
                        end
                        default: begin acc_jog = pont_jogador; acc_addr = pont_addr; end
                    endcase
                end
                e_rvalid = '0;
                if (rdq.size() > 0 && rdq[0].cyc == cyc - int'(RD_LAT)) begin
                    r = rdq.pop_front();
                    e_rvalid[r.owner] = 1'b1;
                    e_rdata = r.jog ? mem_q_p2 : mem_q_p1;
                end
                e_acc = (acc_owner >= 0);
                e_dchk = acc_we;
                e_wr1 = acc_we && !acc_jog;
                e_wr2 = acc_we && acc_jog;
                if (acc_owner >= 0) begin
                    e_addr = acc_addr;
                    e_data = acc_wd;
                    if (!acc_we) rdq.push_back('{cyc: cyc, owner: acc_owner, jog: acc_jog});
                end
                prev = m_owner;
                hit = 1'b0;
                if (acc_owner >= 0 && acc_owner < 3) begin
                    m_burst++;
                    hit = LIMIT_ON && (m_burst == int'(MAX_BURST));
                end
                if (hit) begin
                    m_owner = -1;
                end else if (m_owner < 0 || !req[m_owner]) begin
                    m_owner = -1;
                    for (int k = 2; k >= 0; k--) if (req[k]) m_owner = k;
                end
                if (m_owner != prev) m_burst = 0;
                e_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            end
            cyc++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetGeral = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({val_gnt, col_gnt, pont_gnt, val_rvalid, col_rvalid, pont_rvalid, vga_rvalid,
                 mem_wrenP1, mem_wrenP2} !== 9'b0) begin
                errors++;
                $display("FAIL reset_ctrl got %b want 0", {val_gnt, col_gnt, pont_gnt, val_rvalid,
                         col_rvalid, pont_rvalid, vga_rvalid, mem_wrenP1, mem_wrenP2});
            end
            checks++;
            if (mem_addr !== 5'd0 || mem_data !== 64'd0 || rdata !== 64'd0) begin
                errors++;
                $display("FAIL reset_data got addr %h data %h rdata %h want 0", mem_addr, mem_data,
                         rdata);
            end
            next_cycle();
        end
        resetGeral = 1'b1;
    endtask

    task automatic test_vga_idle();
        vga_addr = 5'd7;
        vga_jogador = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (mem_addr !== 5'd7 || {mem_wrenP2, mem_wrenP1} !== 2'b00) begin
                    errors++;
                    $display("FAIL vga_addr got %0d wren %b want 7 wren 00", mem_addr,
                             {mem_wrenP2, mem_wrenP1});
                end
            end
            if (i >= 2) begin
                checks++;
                if (vga_rvalid !== 1'b1 || rdata !== e_rdata) begin
                    errors++;
                    $display("FAIL vga_rdata got v%b %h want v1 %h", vga_rvalid, rdata, e_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 10; i++) begin
            val_req = (i < 4); col_req = (i < 8);
            val_we = 1'b0; col_we = 1'($urandom);
            val_addr = 5'($urandom); col_addr = 5'($urandom); col_wdata = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (val_gnt !== (i >= 1 && i <= 4) || col_gnt !== (i >= 5 && i <= 8)) begin
                errors++;
                $display("FAIL prio_gnt cyc %0d got val %b col %b", i, val_gnt, col_gnt);
            end
            checks++;
            if ({vga_rvalid, pont_rvalid, col_rvalid, val_rvalid} !== e_rvalid) begin
                errors++;
                $display("FAIL prio_rvalid cyc %0d got %b want %b", i,
                         {vga_rvalid, pont_rvalid, col_rvalid, val_rvalid}, e_rvalid);
            end
            next_cycle();
        end
        col_we = 1'b0;
    endtask

    task automatic test_col_write();
        for (int i = 0; i < 6; i++) begin
            col_req = (i < 2); col_we = 1'b1; col_jogador = 1'b0;
            col_addr = 5'd3; col_wdata = 64'h1;
            @(negedge clk);
            checks++;
            if ({mem_wrenP2, mem_wrenP1} !== ((i == 2) ? 2'b01 : 2'b00) || col_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL colwr_wren cyc %0d got wren %b rvalid %b", i,
                         {mem_wrenP2, mem_wrenP1}, col_rvalid);
            end
            if (i == 2) begin
                checks++;
                if (mem_addr !== 5'd3 || mem_data !== 64'h1) begin
                    errors++;
                    $display("FAIL colwr_data got addr %0d data %h want 3 1", mem_addr, mem_data);
                end
            end
            next_cycle();
        end
        col_we = 1'b0;
    endtask

    task automatic test_pont_read();
        for (int i = 0; i < 8; i++) begin
            pont_req = (i < 2); pont_jogador = 1'b1; pont_addr = 5'($urandom);
            @(negedge clk);
            checks++;
            if (pont_rvalid !== (i == 2 + int'(RD_LAT))) begin
                errors++;
                $display("FAIL pont_rvalid cyc %0d got %b", i, pont_rvalid);
            end
            if (i == 2 + int'(RD_LAT)) begin
                checks++;
                if (rdata !== e_rdata) begin
                    errors++;
                    $display("FAIL pont_rdata got %h want %h", rdata, e_rdata);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_inflight();
        val_req = 1'b1; val_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            val_addr = 5'($urandom); val_jogador = 1'($urandom);
            next_cycle();
        end
        #2 resetGeral = 1'b0;
        #1;
        checks++;
        if ({val_gnt, col_gnt, pont_gnt, val_rvalid, col_rvalid, pont_rvalid, vga_rvalid,
             mem_wrenP1, mem_wrenP2} !== 9'b0 || mem_addr !== 5'd0 || mem_data !== 64'd0 ||
            rdata !== 64'd0) begin
            errors++;
            $display("FAIL rst_async got gnt %b%b%b rv %b%b%b%b addr %0d rdata %h want 0", val_gnt,
                     col_gnt, pont_gnt, val_rvalid, col_rvalid, pont_rvalid, vga_rvalid, mem_addr,
                     rdata);
        end
        next_cycle();
        resetGeral = 1'b1;
        val_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (val_rvalid !== 1'b0 || vga_rvalid !== e_rvalid[3]) begin
                errors++;
                $display("FAIL rst_flush cyc %0d got val_rv %b vga_rv %b want 0 %b", i, val_rvalid,
                         vga_rvalid, e_rvalid[3]);
            end
            next_cycle();
        end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 16; i++) begin
            val_req = (i < 11); pont_req = (i < 14); val_we = 1'b0;
            val_addr = 5'($urandom); pont_addr = 5'($urandom);
            @(negedge clk);
            checks++;
            if ({pont_gnt, col_gnt, val_gnt} !== e_gnt) begin
                errors++;
                $display("FAIL burst_gnt cyc %0d got %b want %b", i, {pont_gnt, col_gnt, val_gnt},
                         e_gnt);
            end
            if (i <= 11) begin
                checks++;
                if (pont_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_pont cyc %0d got %b want 0", i, pont_gnt);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) val_req = ~val_req;
            if ($urandom_range(3) == 0) col_req = ~col_req;
            if ($urandom_range(3) == 0) pont_req = ~pont_req;
            val_we = 1'($urandom); col_we = 1'($urandom);
            val_jogador = 1'($urandom); col_jogador = 1'($urandom); pont_jogador = 1'($urandom);
            val_addr = 5'($urandom); col_addr = 5'($urandom); pont_addr = 5'($urandom);
            vga_addr = 5'($urandom); vga_jogador = 1'($urandom);
            val_wdata = {$urandom, $urandom}; col_wdata = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if ({pont_gnt, col_gnt, val_gnt} !== e_gnt) begin
                errors++;
                $display("FAIL rnd_gnt cyc %0d got %b want %b", i, {pont_gnt, col_gnt, val_gnt},
                         e_gnt);
            end
            checks++;
            if ({vga_rvalid, pont_rvalid, col_rvalid, val_rvalid} !== e_rvalid) begin
                errors++;
                $display("FAIL rnd_rvalid cyc %0d got %b want %b", i,
                         {vga_rvalid, pont_rvalid, col_rvalid, val_rvalid}, e_rvalid);
            end
            if (e_rvalid != 4'b0) begin
                checks++;
                if (rdata !== e_rdata) begin
                    errors++;
                    $display("FAIL rnd_rdata cyc %0d got %h want %h", i, rdata, e_rdata);
                end
            end
            checks++;
            if ({mem_wrenP2, mem_wrenP1} !== {e_wr2, e_wr1}) begin
                errors++;
                $display("FAIL rnd_wren cyc %0d got %b want %b", i, {mem_wrenP2, mem_wrenP1},
                         {e_wr2, e_wr1});
            end
            if (e_acc) begin
                checks++;
                if (mem_addr !== e_addr) begin
                    errors++;
                    $display("FAIL rnd_addr cyc %0d got %0d want %0d", i, mem_addr, e_addr);
                end
            end
            if (e_dchk) begin
                checks++;
                if (mem_data !== e_data) begin
                    errors++;
                    $display("FAIL rnd_data cyc %0d got %h want %h", i, mem_data, e_data);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_vga_idle();
        test_priority();
        test_col_write();
        test_pont_read();
        test_reset_inflight();
        test_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_memoria_tabuleiro.md
# arbitro_memoria_tabuleiro

Arbiter and sequencer for the shared pair of board memories (player 1 and player 2, 32 words × 64 bits each). It shares one address/data port between three requesters, in priority order validator, collider and score. The VGA reader takes every cycle that no requester holds. It sits between the game-logic blocks and the two single-port board RAMs. It replaces the ad-hoc state-per-requester switching with a registered req/gnt handshake and tagged read returns.

## Interface
Parameters:
- RD_LAT, 1: board RAM read latency in cycles (1 or 2).
- MAX_BURST, 32: accesses per grant before a forced release (used only with the burst-limit option).

Ports:
- clk  in  1  system clock.
- resetGeral  in  1  asynchronous, active-low reset.
- val_req, col_req, pont_req  in  1 each  access request; held high for the whole burst.
- val_we, col_we  in  1 each  write qualifier for the current access (score is read-only).
- val_jogador, col_jogador, pont_jogador  in  1 each  target board: 0 = P1, 1 = P2.
- val_addr, col_addr, pont_addr  in  5 each  word address.
- val_wdata, col_wdata  in  64 each  write data.
- val_gnt, col_gnt, pont_gnt  out  1 each  grant (registered).
- val_rvalid, col_rvalid, pont_rvalid, vga_rvalid  out  1 each  read-data strobe.
- rdata  out  64  read data returned to the requester whose rvalid is high.
- vga_addr, vga_jogador  in  5/1  VGA read address and board select.
- mem_addr  out  5  RAM address, shared by both boards.
- mem_data  out  64  RAM write data.
- mem_wrenP1, mem_wrenP2  out  1 each  RAM write enables.
- mem_q_p1, mem_q_p2  in  64 each  RAM read data.

## Operation
- States: IDLE_VGA, GRANT_VAL, GRANT_COL, GRANT_PONT.
- IDLE_VGA: the VGA address and board are issued every cycle. At each edge the highest-priority requester with req=1 wins. The state moves to that requester's GRANT state and its gnt asserts.
- GRANT_x: holds while req_x=1, so the grant is locked with no preemption, even by higher-priority requesters.
- Release: when req_x=0 at an edge, gnt_x drops. Re-arbitration happens on the same edge: the state goes directly to another GRANT state if any req is high, otherwise to IDLE_VGA.
- Access rule: each cycle with gnt_x=1 and req_x=1 issues exactly one access using the addr/we/wdata/jogador sampled in that cycle.
- Write access:
  - mem_wrenP1 = we & ~jogador; mem_wrenP2 = we & jogador.
  - mem_wrenP1 and mem_wrenP2 are never both high.
- Read access: a tag {owner[1:0], jogador} enters an RD_LAT-deep pipeline. On exit, rdata is taken from mem_q_p1 or mem_q_p2 according to the tag's jogador bit, and the rvalid of the tagged owner pulses for one cycle.
- Writes produce no rvalid.
- VGA reads use the same tag pipeline with owner VGA.
- Reset values:
  - state IDLE_VGA.
  - All gnt and rvalid 0.
  - mem_wrenP1/P2 0; mem_addr 0; mem_data 0; rdata 0.
  - Tag pipeline empty.
- Reset mid-burst: the grant and pipeline are discarded and no rvalid is produced for in-flight reads. Any requester must re-request.
- A request whose req is deasserted in the same cycle the grant arrives performs no access.

## Timing
- Request to grant: req high at edge t gives gnt high after edge t (1 cycle).
- Accepted access in cycle c: mem_addr, mem_data and mem_wren are registered and valid in cycle c+1.
- Read data: rvalid and rdata are valid in cycle c+1+RD_LAT, and are registered.
- Throughput: one access per cycle during a burst; back-to-back grants between requesters with zero idle cycles.
- VGA: one read per cycle in IDLE_VGA; the VGA block sees gaps only while a grant is held.

## Configuration
- ARB_BURST_LIMIT_EN defined: a per-grant 6-bit counter counts accepted accesses.
  - After MAX_BURST accesses, gnt_x drops for at least one cycle even if req_x stays high.
  - The arbiter spends exactly one cycle in IDLE_VGA, then re-arbitrates by priority.
- ARB_BURST_LIMIT_EN undefined: the counter is absent and a grant lasts as long as req is held.

## Structure
- Shared package holds:
  - state encoding constants (2-bit).
  - owner codes: VAL=0, COL=1, PONT=2, VGA=3.
  - board word width (64) and address width (5).
- Sub-module read_tag_pipe: RD_LAT-stage shift register of {valid, owner, jogador}, with asynchronous clear.

## Test plan
- Idle, all req=0, RD_LAT=1, vga_addr=5'd7, vga_jogador=1, mem_q_p2 returns 64'hA5 → mem_addr=7 one cycle later; vga_rvalid with rdata=64'hA5 two cycles later, each cycle.
- val_req and col_req raised in the same cycle → val_gnt after 1 cycle; col_gnt only in the cycle after val_req drops; no idle gap between.
- col write: we=1, jogador=0, addr=3, wdata=64'h1 → mem_wrenP1=1, mem_wrenP2=0, mem_addr=3, mem_data=1 for one cycle; no col_rvalid.
- pont read on P2 with RD_LAT=2 → pont_rvalid exactly 3 cycles after the accepted cycle, with rdata=mem_q_p2.
- resetGeral pulsed low while 2 reads are in flight → all outputs 0 immediately; no rvalid after release.
- ARB_BURST_LIMIT_EN, MAX_BURST=4, val_req held for 10 cycles, pont_req also high → val_gnt drops after 4 accesses; one VGA cycle; val regains the grant; pont_gnt stays 0 while val_req is high.
